execute_stage: RTL

Execute stage of the pipelined LC-3 datapath, directly downstream of the decode stage. It consumes the registered instruction, next-PC and E/M/W control fields produced by decode, plus register-file read data. It computes the ALU result, the memory/branch target address and the branch condition mask, and registers these with the pass-through M/W controls for the memory and writeback stages.

---
 rtl/execute_stage.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//
// Execute stage of the pipelined LC-3 datapath. It takes the registered
// instruction, next-PC and control fields from decode together with the
// register-file read data. It computes the ALU result, the address/target sum
// and the branch condition mask, then registers them with the pass-through
// memory/writeback controls for the downstream stages.
//
// Optional feature macro: EXEC_BYPASS_EN
//   defined   -> operands may be forwarded from this stage's own aluout or
//                from the memory stage (Mem_Bypass_Val); ALU forwarding wins.
//   undefined -> bypass ports are present but ignored; operands come straight
//                from VSR1/VSR2.
//
// Ports
//   clock, reset          single clock, synchronous active-high reset
//   enable_execute        capture enable; low holds every register
//   E_Control[5:0]        {alu_control[5:4], pcselect1[3:2], pcselect2[1], op2select[0]}
//   IR, npc_in            instruction and next PC from decode
//   Mem_Control_in        indirect memory access flag (LDI/STI)
//   W_Control_in[1:0]     writeback select
//   VSR1, VSR2            register-file data for sr1/sr2
//   bypass_alu_1/2        forward own aluout into operand 1/2
//   bypass_mem_1/2        forward Mem_Bypass_Val into operand 1/2
//   Mem_Bypass_Val        value returned by the memory stage
//   aluout, pcout, NZP    registered ALU result, address sum, condition mask
//   W_Control_out, Mem_Control_out, M_Data, IR_Exec, dr  registered pass-through
//   sr1, sr2              combinational register-file read addresses
// -----------------------------------------------------------------------------
module execute_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_execute,
  input  logic [5:0]  E_Control,
  input  logic [15:0] IR,
  input  logic [15:0] npc_in,
  input  logic        Mem_Control_in,
  input  logic [1:0]  W_Control_in,
  input  logic [15:0] VSR1,
  input  logic [15:0] VSR2,
  input  logic        bypass_alu_1,
  input  logic        bypass_alu_2,
  input  logic        bypass_mem_1,
  input  logic        bypass_mem_2,
  input  logic [15:0] Mem_Bypass_Val,
  output logic [15:0] aluout,
  output logic [15:0] pcout,
  output logic [2:0]  NZP,
  output logic [1:0]  W_Control_out,
  output logic        Mem_Control_out,
  output logic [15:0] M_Data,
  output logic [15:0] IR_Exec,
  output logic [2:0]  dr,
  output logic [2:0]  sr1,
  output logic [2:0]  sr2
);

  logic [1:0]  alu_control;
  logic [1:0]  pcselect1;
  logic        pcselect2;
  logic        op2select;

  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] alu_b;
  logic [15:0] alu_result;
  logic [15:0] addend1;
  logic [15:0] addend2;
  logic [15:0] pc_sum;
  logic [2:0]  nzp_next;

  assign alu_control = E_Control[5:4];
  assign pcselect1   = E_Control[3:2];
  assign pcselect2   = E_Control[1];
  assign op2select   = E_Control[0];

  // Stores (IR[13:12]==11) read their data register from the dr field, so
  // the second read port must point there for M_Data to be correct.
  assign sr1 = IR[8:6];
  assign sr2 = (IR[13:12] == 2'b11) ? IR[11:9] : IR[2:0];

`ifdef EXEC_BYPASS_EN
  // Forwarding from our own registered result takes priority because it is
  // the younger producer of the two.
  always_comb begin
    op_a = VSR1;
    if (bypass_alu_1)      op_a = aluout;
    else if (bypass_mem_1) op_a = Mem_Bypass_Val;
    op_b = VSR2;
    if (bypass_alu_2)      op_b = aluout;
    else if (bypass_mem_2) op_b = Mem_Bypass_Val;
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{bypass_alu_1, bypass_alu_2, bypass_mem_1,
                           bypass_mem_2, Mem_Bypass_Val};
  assign op_a = VSR1;
  assign op_b = VSR2;
`endif

  // ALU: imm5 is sign-extended when op2select selects the immediate form.
  always_comb begin
    alu_b = op2select ? op_b : {{11{IR[4]}}, IR[4:0]};
    case (alu_control)
      2'd1:    alu_result = op_a & alu_b;
      2'd2:    alu_result = ~op_a;
      default: alu_result = op_a + alu_b;
    endcase
  end

  // Address adder: offset field chosen by pcselect1, base by pcselect2.
  // The sum is deliberately truncated; wrap-around is legal on LC-3.
  always_comb begin
    case (pcselect1)
      2'd0:    addend1 = {{5{IR[10]}}, IR[10:0]};
      2'd1:    addend1 = {{7{IR[8]}},  IR[8:0]};
      2'd2:    addend1 = {{10{IR[5]}}, IR[5:0]};
      default: addend1 = 16'h0000;
    endcase
    addend2 = pcselect2 ? npc_in : op_a;
    pc_sum  = addend1 + addend2;
  end

  // Condition mask: ALU ops report the sign of their result, BR passes its
  // own nzp field through, JMP is unconditional, everything else is never.
  always_comb begin
    nzp_next = 3'b000;
    if (IR[13:12] == 2'b01)
      nzp_next = {alu_result[15], (alu_result == 16'h0000),
                  ~alu_result[15] & (alu_result != 16'h0000)};
    else if (IR[15:12] == 4'b0000)
      nzp_next = IR[11:9];
    else if (IR[15:12] == 4'b1100)
      nzp_next = 3'b111;
  end

  // Pipeline register toward memory/writeback; reset beats enable.
  always_ff @(posedge clock) begin
    if (reset) begin
      aluout          <= 16'h0000;
      pcout           <= 16'h0000;
      NZP             <= 3'b000;
      W_Control_out   <= 2'b00;
      Mem_Control_out <= 1'b0;
      M_Data          <= 16'h0000;
      IR_Exec         <= 16'h0000;
      dr              <= 3'b000;
    end else if (enable_execute) begin
      aluout          <= alu_result;
      pcout           <= pc_sum;
      NZP             <= nzp_next;
      W_Control_out   <= W_Control_in;
      Mem_Control_out <= Mem_Control_in;
      M_Data          <= op_b;
      IR_Exec         <= IR;
      dr              <= IR[11:9];
    end
  end

endmodule
